rename_regfile_ckpt: RTL
========================

Name: rename_regfile_ckpt

Overview:
- Parametrised architectural register file with a rename tag table; sits between the decoder, the ROB and the issue stage.
- Each architectural register holds a committed value and an optional busy tag naming the ROB entry that will produce it. Read ports return either the value or the tag.
- Successor to the single-flush register status table. It adds a configurable number of read ports, a commit write path with same-cycle bypass, and branch checkpoints that snapshot the tag table and restore it on mispredict without a full flush.

Parameters:
- XLEN, 32, data width.
- REG_NUM, 32, number of architectural registers (power of two); REG_W = log2(REG_NUM).
- ROB_W, 4, ROB index width (ROB depth 2^ROB_W).
- RD_PORTS, 2, number of combinational read ports.
- CKPT_NUM, 4, number of tag-table checkpoints; CKPT_W = log2(CKPT_NUM).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- rdy  in  1  global enable; when low, all state holds.
- rollback  in  1  full flush: clears all busy bits and invalidates every checkpoint.
- rd_addr  in  RD_PORTS*REG_W  read addresses; port k occupies bits [k*REG_W +: REG_W].
- rd_val  out  RD_PORTS*XLEN  read values.
- rd_busy  out  RD_PORTS  1 = value pending; the tag is valid.
- rd_tag  out  RD_PORTS*ROB_W  producing ROB entry.
- issue  in  1  rename strobe.
- issue_rd  in  REG_W  destination register of the renamed instruction.
- issue_rob_pos  in  ROB_W  ROB entry of the renamed instruction.
- commit  in  1  ROB commit strobe.
- commit_rd  in  REG_W  destination register of the committing instruction.
- commit_val  in  XLEN  committed value.
- commit_rob_pos  in  ROB_W  ROB entry that is committing.
- ckpt_save  in  1  take a snapshot into slot ckpt_save_id.
- ckpt_save_id  in  CKPT_W  snapshot slot to write.
- ckpt_restore  in  1  restore the tag table from slot ckpt_restore_id.
- ckpt_restore_id  in  CKPT_W  snapshot slot to restore.
- ckpt_release  in  1  free slot ckpt_release_id (branch resolved correctly).
- ckpt_release_id  in  CKPT_W  snapshot slot to free.
- ckpt_valid  out  CKPT_NUM  per-slot valid bits.

Behaviour:
- Reset (rst low, asynchronous):
  - All values are 0, all busy bits 0, all tags 0, ckpt_valid = 0.
  - Read outputs are combinational, so during reset they read 0 with busy 0.
- Register 0:
  - Always reads value 0, busy 0, tag 0.
  - Issue and commit to register 0 are ignored.
- Reads (combinational, per port):
  - If commit, commit_rd == rd_addr, commit_rd != 0, busy[commit_rd] is set and tag[commit_rd] == commit_rob_pos, the port returns commit_val with busy 0 (bypass).
  - Otherwise the port returns the stored value, busy bit and tag.
  - A same-cycle issue never affects reads: reads see the pre-issue mapping, so "add x1,x1,x1" reads the old x1.
- Sequential update, applied only when rdy is high, in this order:
  1. Commit (commit_rd != 0):
     - Write val[commit_rd] unconditionally.
     - If busy and tag match commit_rob_pos, clear busy.
     - In every valid checkpoint, clear the busy bit of commit_rd if its saved tag matches commit_rob_pos.
  2. Restore (ckpt_restore and slot valid, rollback low):
     - Replace all busy bits and tags with the slot contents, with step 1's checkpoint clearing already applied.
     - Clear that slot's valid bit.
     - Issue and save in the same cycle are ignored.
     - Restore of an invalid slot is a no-op.
  3. Issue (issue, issue_rd != 0, no restore, no rollback):
     - busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_pos.
     - Issue overrides a same-cycle commit clear on the same register.
  4. Save (ckpt_save, no restore, no rollback):
     - The slot captures the table after steps 1 and 3, so the branch's own rd rename is included.
     - Set the slot's valid bit.
     - Saving over a valid slot overwrites it.
  5. Release: clear the slot's valid bit. Save to the same slot in the same cycle wins, leaving the slot valid.
  6. Rollback: clear all busy bits and all ckpt_valid bits. Rollback has highest priority over restore, issue and save.
- Values are never rolled back; only tags and busy bits are.
- Commit with a stale tag (register since re-renamed) writes the value but leaves busy and tag untouched.
- rdy low: no state changes; combinational reads remain active.

Test Plan:
- Reset, then read x5 on both ports -> val 0, busy 0. Commit x0 with 0xDEAD -> x0 still reads 0.
- Issue x3 to ROB 7; next cycle read x3 -> busy 1, tag 7. In the same cycle commit x3/ROB 7/0x1234 -> bypassed read shows 0x1234, busy 0. Next cycle, stored value 0x1234, busy 0.
- Issue x4 to ROB 2, then issue x4 to ROB 5, then commit x4/ROB 2/0xAA -> x4 value 0xAA but busy 1, tag 5.
- Issue x6 to ROB 1. Save slot 2 together with issue x7 to ROB 3. Issue x6 to ROB 9. Commit ROB 1 (x6 = 0x55) -> slot 2's x6 entry is cleared. Restore slot 2 -> x6 busy 0, value 0x55; x7 busy 1, tag 3; ckpt_valid[2] = 0.
- Save slots 0 and 1, then rollback in the same cycle as a restore of slot 0 and an issue of x8 -> all busy 0, ckpt_valid = 0, x8 not busy.
- Hold rdy low while strobing issue, commit and save -> no change. Assert rst low mid-sequence -> all outputs return to zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rename_regfile_ckpt.sv
// Architectural register file with rename tag table and branch checkpoints.
// Reads return either the committed value or the busy ROB tag; commit bypasses into reads.
module rename_regfile_ckpt #(
    parameter  int XLEN     = 32,
    parameter  int REG_NUM  = 32,
    parameter  int ROB_W    = 4,
    parameter  int RD_PORTS = 2,
    parameter  int CKPT_NUM = 4,
    localparam int REG_W    = $clog2(REG_NUM),
    localparam int CKPT_W   = $clog2(CKPT_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rollback,
    input  logic [RD_PORTS*REG_W-1:0] rd_addr,
    output logic [RD_PORTS*XLEN-1:0]  rd_val,
    output logic [RD_PORTS-1:0]       rd_busy,
    output logic [RD_PORTS*ROB_W-1:0] rd_tag,
    input  logic                      issue,
    input  logic [REG_W-1:0]          issue_rd,
    input  logic [ROB_W-1:0]          issue_rob_pos,
    input  logic                      commit,
    input  logic [REG_W-1:0]          commit_rd,
    input  logic [XLEN-1:0]           commit_val,
    input  logic [ROB_W-1:0]          commit_rob_pos,
    input  logic                      ckpt_save,
    input  logic [CKPT_W-1:0]         ckpt_save_id,
    input  logic                      ckpt_restore,
    input  logic [CKPT_W-1:0]         ckpt_restore_id,
    input  logic                      ckpt_release,
    input  logic [CKPT_W-1:0]         ckpt_release_id,
    output logic [CKPT_NUM-1:0]       ckpt_valid
);

    logic [XLEN-1:0]    val_reg  [REG_NUM];
    logic [REG_NUM-1:0] busy_reg;
    logic [ROB_W-1:0]   tag_reg  [REG_NUM];

    logic [REG_NUM-1:0] ckpt_busy_reg  [CKPT_NUM];
    logic [ROB_W-1:0]   ckpt_tag_reg   [CKPT_NUM][REG_NUM];
    logic [CKPT_NUM-1:0] ckpt_valid_reg;

    logic commit_en, restore_en, issue_en, save_en;

    logic [REG_NUM-1:0]  busy_cl;
    logic [REG_NUM-1:0]  ckpt_busy_cl [CKPT_NUM];
    logic [REG_NUM-1:0]  busy_next;
    logic [ROB_W-1:0]    tag_next [REG_NUM];
    logic [CKPT_NUM-1:0] ckpt_valid_next;

    assign commit_en  = commit && (commit_rd != '0);
    assign restore_en = ckpt_restore && ckpt_valid_reg[ckpt_restore_id] && !rollback;
    assign issue_en   = issue && (issue_rd != '0) && !restore_en && !rollback;
    assign save_en    = ckpt_save && !restore_en && !rollback;

    // Commit clears the live table and every live snapshot whose tag still matches.
    always_comb begin
        busy_cl = busy_reg;
        if (commit_en && tag_reg[commit_rd] == commit_rob_pos)
            busy_cl[commit_rd] = 1'b0;
        for (int c = 0; c < CKPT_NUM; c++) begin
            ckpt_busy_cl[c] = ckpt_busy_reg[c];
            if (commit_en && ckpt_valid_reg[c] && ckpt_tag_reg[c][commit_rd] == commit_rob_pos)
                ckpt_busy_cl[c][commit_rd] = 1'b0;
        end
    end

    always_comb begin
        busy_next = busy_cl;
        for (int r = 0; r < REG_NUM; r++)
            tag_next[r] = tag_reg[r];
        if (restore_en) begin
            busy_next = ckpt_busy_cl[ckpt_restore_id];
            for (int r = 0; r < REG_NUM; r++)
                tag_next[r] = ckpt_tag_reg[ckpt_restore_id][r];
        end else if (issue_en) begin
            busy_next[issue_rd] = 1'b1;
            tag_next[issue_rd]  = issue_rob_pos;
        end
        if (rollback)
            busy_next = '0;
    end

    // Save is applied after the release clear so a same-slot save wins.
    always_comb begin
        ckpt_valid_next = ckpt_valid_reg;
        if (restore_en)
            ckpt_valid_next[ckpt_restore_id] = 1'b0;
        if (ckpt_release)
            ckpt_valid_next[ckpt_release_id] = 1'b0;
        if (save_en)
            ckpt_valid_next[ckpt_save_id] = 1'b1;
        if (rollback)
            ckpt_valid_next = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg       <= '0;
            ckpt_valid_reg <= '0;
            for (int r = 0; r < REG_NUM; r++) begin
                val_reg[r] <= '0;
                tag_reg[r] <= '0;
            end
            for (int c = 0; c < CKPT_NUM; c++) begin
                ckpt_busy_reg[c] <= '0;
                for (int r = 0; r < REG_NUM; r++)
                    ckpt_tag_reg[c][r] <= '0;
            end
        end else if (rdy) begin
            if (commit_en)
                val_reg[commit_rd] <= commit_val;
            busy_reg <= busy_next;
            for (int r = 0; r < REG_NUM; r++)
                tag_reg[r] <= tag_next[r];
            // A snapshot captures the table after this cycle's issue.
            for (int c = 0; c < CKPT_NUM; c++) begin
                if (save_en && ckpt_save_id == CKPT_W'(c)) begin
                    ckpt_busy_reg[c] <= busy_next;
                    for (int r = 0; r < REG_NUM; r++)
                        ckpt_tag_reg[c][r] <= tag_next[r];
                end else begin
                    ckpt_busy_reg[c] <= ckpt_busy_cl[c];
                end
            end
            ckpt_valid_reg <= ckpt_valid_next;
        end
    end

    assign ckpt_valid = ckpt_valid_reg;

    generate
        for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            logic [REG_W-1:0] addr;
            logic             is_zero;
            logic             hit;
            assign addr    = rd_addr[gi*REG_W +: REG_W];
            assign is_zero = (addr == '0);
            // Bypass only when the commit retires the producer the table is waiting on.
            assign hit = commit && (commit_rd == addr) && (commit_rd != '0)
                         && busy_reg[addr] && (tag_reg[addr] == commit_rob_pos);
            assign rd_val[gi*XLEN +: XLEN]   = is_zero ? '0 : (hit ? commit_val : val_reg[addr]);
            assign rd_busy[gi]               = is_zero ? 1'b0 : (hit ? 1'b0 : busy_reg[addr]);
            assign rd_tag[gi*ROB_W +: ROB_W] = is_zero ? '0 : tag_reg[addr];
        end
    endgenerate

endmodule
